// File: rtl/branch_cond_if.sv
// Control-unit side bundle of the branch condition unit: operand bus,
// evaluate/acknowledge handshake, decision outputs and taken-branch counter.
interface branch_cond_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic signed [DATA_W-1:0] bus_in;
  logic                     opa_ld;
  logic                     cmp_mode;
  logic        [2:0]        cond_sel;
  logic                     con_in;
  logic                     con_ack;
  logic                     cnt_clr;
  logic                     con_out;
  logic                     con_valid;
  logic                     overrun;
  logic        [CNT_W-1:0]  taken_count;

  modport master (
    output bus_in, opa_ld, cmp_mode, cond_sel, con_in, con_ack, cnt_clr,
    input  con_out, con_valid, overrun, taken_count
  );

  modport slave (
    input  bus_in, opa_ld, cmp_mode, cond_sel, con_in, con_ack, cnt_clr,
    output con_out, con_valid, overrun, taken_count
  );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch condition unit: signed compare of bus_in against zero or a latched
// operand, with a one-deep result hold, overrun flag and saturating taken count.
module branch_cond_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          clear,
  branch_cond_if.slave  bc
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                   state_q;
  logic signed [DATA_W-1:0] opa_q;
  logic                     con_out_q;
  logic                     con_valid_q;
  logic                     overrun_q;
  logic        [CNT_W-1:0]  taken_q;

  logic signed [DATA_W-1:0] ref_v;
  logic                     flag;
  logic                     accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Both operands are signed, so relational operators are overflow-free.
  always_comb begin
    ref_v = bc.cmp_mode ? opa_q : '0;
    flag  = 1'b0;
    case (bc.cond_sel)
      3'b000:  flag = (bc.bus_in == ref_v);
      3'b001:  flag = (bc.bus_in != ref_v);
      3'b010:  flag = (bc.bus_in >= ref_v);
      3'b011:  flag = (bc.bus_in <  ref_v);
      3'b100:  flag = (bc.bus_in >  ref_v);
      3'b101:  flag = (bc.bus_in <= ref_v);
      3'b110:  flag = 1'b1;
      default: flag = 1'b0;
    endcase
  end

  // A request is taken in IDLE, or in HOLD only when the held result is acked.
  assign accept = bc.con_in && ((state_q == IDLE) || bc.con_ack);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      con_out_q   <= 1'b0;
      con_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      taken_q     <= '0;
    end else begin
      if (bc.opa_ld) opa_q <= bc.bus_in;

      case (state_q)
        IDLE: begin
          if (bc.con_in) begin
            con_out_q   <= flag;
            con_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (bc.con_ack) begin
            if (bc.con_in) begin
              con_out_q <= flag;
            end else begin
              con_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end else if (bc.con_in) begin
            overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (bc.cnt_clr)            taken_q <= '0;
      else if (accept && flag)   taken_q <= sat_inc(taken_q);
    end
  end

  assign bc.con_out     = con_out_q;
  assign bc.con_valid   = con_valid_q;
  assign bc.overrun     = overrun_q;
  assign bc.taken_count = taken_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: condition table, directed handshake sequences,
// a CNT_W=2 saturation instance and a randomized run against a reference model.
module tb_branch_cond_unit;

  logic clk = 1'b0;
  logic clear1, clear2;
  always #5 clk = ~clk;

  branch_cond_if #(.DATA_W(32), .CNT_W(16)) bc1 ();
  branch_cond_if #(.DATA_W(32), .CNT_W(2))  bc2 ();

  branch_cond_unit #(.DATA_W(32), .CNT_W(16)) u1 (.clk(clk), .clear(clear1), .bc(bc1));
  branch_cond_unit #(.DATA_W(32), .CNT_W(2))  u2 (.clk(clk), .clear(clear2), .bc(bc2));

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] bus;
    logic [31:0] opa;
    logic        mode;
    logic [2:0]  sel;
    logic        exp;
  } vec_t;
  vec_t vt[14];

  logic        m_out, m_valid, m_ovr;
  int          m_cnt;
  logic [31:0] m_opa;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: compare via 64-bit signed difference, which cannot overflow.
  function automatic logic ref_flag(input logic [31:0] a, input logic [31:0] r, input logic [2:0] sel);
    longint d;
    d = longint'($signed(a)) - longint'($signed(r));
    case (sel)
      3'd0: return d == 0;
      3'd1: return d != 0;
      3'd2: return d >= 0;
      3'd3: return d < 0;
      3'd4: return d > 0;
      3'd5: return d <= 0;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle1();
    bc1.opa_ld = 0; bc1.con_in = 0; bc1.con_ack = 0; bc1.cnt_clr = 0;
  endtask

  initial begin
    vt[0]  = '{32'h0000_0000, 32'h0,          1'b0, 3'd0, 1'b1};
    vt[1]  = '{32'h0000_0000, 32'h0,          1'b0, 3'd1, 1'b0};
    vt[2]  = '{32'h8000_0000, 32'h7FFF_FFFF,  1'b1, 3'd3, 1'b1};
    vt[3]  = '{32'h8000_0000, 32'h7FFF_FFFF,  1'b1, 3'd4, 1'b0};
    vt[4]  = '{32'h7FFF_FFFF, 32'h8000_0000,  1'b1, 3'd4, 1'b1};
    vt[5]  = '{32'h8000_0000, 32'h0,          1'b0, 3'd2, 1'b0};
    vt[6]  = '{32'hFFFF_FFFF, 32'h0,          1'b0, 3'd3, 1'b1};
    vt[7]  = '{32'h0000_0000, 32'h0,          1'b0, 3'd2, 1'b1};
    vt[8]  = '{32'h0000_0000, 32'h0,          1'b0, 3'd4, 1'b0};
    vt[9]  = '{32'h0000_0005, 32'h5,          1'b1, 3'd5, 1'b1};
    vt[10] = '{32'h0000_0005, 32'h5,          1'b1, 3'd0, 1'b1};
    vt[11] = '{32'h1234_5678, 32'h0,          1'b0, 3'd6, 1'b1};
    vt[12] = '{32'h0000_0000, 32'h0,          1'b0, 3'd7, 1'b0};
    vt[13] = '{32'hFFFF_FFFD, 32'h5,          1'b1, 3'd2, 1'b0};

    bc1.bus_in = 0; bc1.cmp_mode = 0; bc1.cond_sel = 0; idle1();
    bc2.bus_in = 0; bc2.cmp_mode = 0; bc2.cond_sel = 3'd6;
    bc2.opa_ld = 0; bc2.con_in = 0; bc2.con_ack = 0; bc2.cnt_clr = 0;
    clear1 = 1; clear2 = 1;
    tick(); tick();
    clear1 = 0; clear2 = 0;

    chk("rst_con_out", bc1.con_out, 0);
    chk("rst_con_valid", bc1.con_valid, 0);
    chk("rst_overrun", bc1.overrun, 0);
    chk("rst_taken", bc1.taken_count, 0);

    // Condition table
    foreach (vt[i]) begin
      bc1.opa_ld = 1; bc1.bus_in = vt[i].opa; tick();
      bc1.opa_ld = 0;
      bc1.bus_in = vt[i].bus; bc1.cmp_mode = vt[i].mode; bc1.cond_sel = vt[i].sel;
      bc1.con_in = 1; tick();
      bc1.con_in = 0;
      chk($sformatf("vec%0d_out", i), bc1.con_out, vt[i].exp);
      chk($sformatf("vec%0d_valid", i), bc1.con_valid, 1);
      bc1.con_ack = 1; tick();
      bc1.con_ack = 0;
      chk($sformatf("vec%0d_ackvalid", i), bc1.con_valid, 0);
      chk($sformatf("vec%0d_held", i), bc1.con_out, vt[i].exp);
    end

    // Operand load, evaluation and taken count
    clear1 = 1; tick(); clear1 = 0;
    bc1.opa_ld = 1; bc1.bus_in = 5; tick(); bc1.opa_ld = 0;
    bc1.cmp_mode = 1; bc1.bus_in = -3; bc1.cond_sel = 3'd4; bc1.con_in = 1; tick();
    chk("seq30_gt", bc1.con_out, 0);
    chk("seq30_cnt0", bc1.taken_count, 0);
    bc1.cond_sel = 3'd3; bc1.con_ack = 1; tick();
    chk("seq30_lt", bc1.con_out, 1);
    chk("seq30_cnt1", bc1.taken_count, 1);
    chk("seq30_b2b_valid", bc1.con_valid, 1);
    // Dropped request while holding
    bc1.con_ack = 0; bc1.cond_sel = 3'd7; tick();
    chk("ovr_set", bc1.overrun, 1);
    chk("ovr_out_kept", bc1.con_out, 1);
    chk("ovr_valid_kept", bc1.con_valid, 1);
    chk("ovr_cnt", bc1.taken_count, 1);
    bc1.con_ack = 1; tick();
    chk("b2b_new_out", bc1.con_out, 0);
    chk("b2b_valid", bc1.con_valid, 1);
    bc1.con_in = 0; tick();
    chk("release_valid", bc1.con_valid, 0);
    chk("ovr_sticky", bc1.overrun, 1);
    // Ack in IDLE is ignored
    tick();
    chk("idle_ack_valid", bc1.con_valid, 0);
    bc1.con_ack = 0;
    // Coincident operand load uses old operand (5): 7 > 5, then 7 == 7
    bc1.bus_in = 7; bc1.cond_sel = 3'd4; bc1.opa_ld = 1; bc1.con_in = 1; tick();
    chk("opa_old_used", bc1.con_out, 1);
    bc1.opa_ld = 0; bc1.cond_sel = 3'd0; bc1.con_ack = 1; tick();
    chk("opa_new_used", bc1.con_out, 1);
    chk("opa_cnt", bc1.taken_count, 3);
    // Clear while holding, with coincident request
    bc1.con_ack = 0; bc1.cond_sel = 3'd6; clear1 = 1; tick(); clear1 = 0;
    bc1.con_in = 0;
    chk("clr_out", bc1.con_out, 0);
    chk("clr_valid", bc1.con_valid, 0);
    chk("clr_ovr", bc1.overrun, 0);
    chk("clr_cnt", bc1.taken_count, 0);
    // After clear, opa is 0: bus 0 equals opa
    bc1.bus_in = 0; bc1.cmp_mode = 1; bc1.cond_sel = 3'd0; bc1.con_in = 1; tick();
    bc1.con_in = 0;
    chk("clr_opa_zero", bc1.con_out, 1);
    bc1.con_ack = 1; tick(); bc1.con_ack = 0;

    // Saturation with CNT_W=2
    bc2.con_in = 1; bc2.con_ack = 1;
    repeat (5) tick();
    chk("sat_cnt", bc2.taken_count, 3);
    bc2.cnt_clr = 1; tick();
    chk("cntclr_prio", bc2.taken_count, 0);
    chk("cntclr_valid", bc2.con_valid, 1);
    bc2.cnt_clr = 0; tick();
    chk("cnt_after_clr", bc2.taken_count, 1);
    bc2.con_in = 0; bc2.con_ack = 0;

    // Randomized run against the reference model
    clear1 = 1; tick(); clear1 = 0;
    m_out = 0; m_valid = 0; m_ovr = 0; m_cnt = 0; m_opa = 0;
    for (int k = 0; k < 600; k++) begin
      logic [31:0] b;
      logic        f, acc;
      case ($urandom_range(0, 5))
        0: b = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: b = 32'h0;
        3: b = $urandom_range(0, 6) - 3;
        default: b = $urandom;
      endcase
      bc1.bus_in   = b;
      bc1.cmp_mode = $urandom_range(0, 1);
      bc1.cond_sel = $urandom_range(0, 7);
      bc1.con_in   = $urandom_range(0, 1);
      bc1.con_ack  = $urandom_range(0, 1);
      bc1.opa_ld   = ($urandom_range(0, 4) == 0);
      bc1.cnt_clr  = ($urandom_range(0, 19) == 0);
      clear1       = ($urandom_range(0, 39) == 0);

      if (clear1) begin
        m_out = 0; m_valid = 0; m_ovr = 0; m_cnt = 0; m_opa = 0;
      end else begin
        f   = ref_flag(b, bc1.cmp_mode ? m_opa : 32'h0, bc1.cond_sel);
        acc = bc1.con_in && (!m_valid || bc1.con_ack);
        if (m_valid && bc1.con_in && !bc1.con_ack) m_ovr = 1;
        if (acc) begin
          m_out = f; m_valid = 1;
        end else if (m_valid && bc1.con_ack) begin
          m_valid = 0;
        end
        if (bc1.opa_ld) m_opa = b;
        if (bc1.cnt_clr) m_cnt = 0;
        else if (acc && f && m_cnt < 65535) m_cnt++;
      end
      tick();
      chk("rnd_out", bc1.con_out, m_out);
      chk("rnd_valid", bc1.con_valid, m_valid);
      chk("rnd_ovr", bc1.overrun, m_ovr);
      chk("rnd_cnt", bc1.taken_count, m_cnt);
    end
    clear1 = 0; idle1();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of bus_in and the operand register.
REQ-002 Parameter CNT_W, default 16: width of the taken-branch counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clear  input  1  reset; synchronous, active-high.
REQ-005 bus_in  input  DATA_W  value under test; signed two's complement.
REQ-006 opa_ld  input  1  strobe; latch bus_in into operand register opa.
REQ-007 cmp_mode  input  1  0 = test bus_in against zero; 1 = test bus_in against opa.
REQ-008 cond_sel  input  3  condition select (REQ-013).
REQ-009 con_in  input  1  evaluate strobe; one-cycle pulse requests an evaluation.
REQ-010 con_ack  input  1  control unit consumed the result.
REQ-011 con_out  output  1  registered branch decision.
REQ-012 con_valid  output  1  con_out holds an unacknowledged result; overrun  output  1  sticky dropped-request flag; taken_count  output  CNT_W  saturating taken count; cnt_clr  input  1  zero taken_count.

Function
REQ-013 The reference value R SHALL be 0 when cmp_mode=0 and opa when cmp_mode=1; the conditions, all signed and full DATA_W, are: 000 bus_in==R, 001 bus_in!=R, 010 bus_in>=R, 011 bus_in<R, 100 bus_in>R, 101 bus_in<=R, 110 always 1, 111 always 0.
REQ-014 Signed comparisons SHALL be overflow-correct (e.g. bus_in=0x80000000, opa=0x7FFFFFFF, sel 011 -> 1).
REQ-015 With cmp_mode=0, sel 010/011 SHALL reduce to MSB==0 / MSB==1.
REQ-016 FSM states: IDLE, HOLD; reset state IDLE.
REQ-017 IDLE & con_in: flag evaluated from same-cycle bus_in/cond_sel/cmp_mode/opa; next cycle con_out=flag, con_valid=1, state HOLD (latency 1 cycle).
REQ-018 HOLD & con_ack & !con_in: next cycle con_valid=0, state IDLE; con_out SHALL keep its value.
REQ-019 HOLD & con_ack & con_in: back-to-back accept; new flag loaded, con_valid stays 1, state HOLD.
REQ-020 HOLD & con_in & !con_ack: request dropped, con_out/con_valid unchanged, overrun set to 1 next cycle.
REQ-021 con_ack in IDLE SHALL be ignored.
REQ-022 opa_ld SHALL be accepted in any state; if opa_ld and con_in coincide, evaluation uses the old opa, opa updates at the same edge.
REQ-023 Each accepted evaluation with flag=1 SHALL increment taken_count by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-024 cnt_clr SHALL zero taken_count next cycle and take priority over a coincident increment.
REQ-025 overrun SHALL be cleared only by clear.

Reset
REQ-026 clear SHALL take priority over all other inputs.
REQ-027 After clear: state IDLE, con_out=0, con_valid=0, overrun=0, taken_count=0, opa=0.
REQ-028 clear during HOLD SHALL abandon the pending result; a con_in coincident with clear SHALL be discarded.

Verification
REQ-029 cmp_mode=0, bus_in=0, sel 000, con_in -> next cycle con_out=1, con_valid=1; con_ack -> con_valid=0, con_out=1 held.
REQ-030 opa_ld with bus_in=5; then cmp_mode=1, bus_in=-3, sel 100 -> con_out=0; sel 011 -> con_out=1; taken_count increments only on the 1.
REQ-031 In HOLD, con_in without con_ack -> overrun=1, con_out unchanged; con_in with con_ack -> new result, con_valid continuously 1.
REQ-032 CNT_W=2: five taken evaluations -> taken_count=3 (saturated); cnt_clr coincident with a taken evaluation -> taken_count=0.
REQ-033 clear asserted in HOLD together with con_in -> next cycle all outputs 0, state IDLE, taken_count=0.
